// File: rtl/mul_seq_param.sv
// Sequential shift-and-add multiplier, one partial product per clock, with
// signed/unsigned operand handling and an early exit for zero operands.
module mul_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mcand, mplier;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc, addend, acc_next;
  logic [CW-1:0]    cnt;
  logic             neg;
  logic             last_step;
  logic             zero_op;

  // Magnitudes are taken in WIDTH bits; the most negative value maps onto
  // its own bit pattern, which reads correctly as an unsigned magnitude.
  always_comb begin
    a_mag     = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
    b_mag     = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
    zero_op   = (a_in == '0) || (b_in == '0);
    addend    = PW'(mcand) << cnt;
    acc_next  = mplier[0] ? (acc + addend) : acc;
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = zero_op ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The final CALC step folds its own partial product straight into the
  // result, so product appears on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            if (zero_op) product <= '0;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last_step) product <= neg ? -acc_next : acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_param.sv
// Randomised and directed checks of mul_seq_param (WIDTH=16) against an
// arithmetic reference product computed with 64-bit integers.
module tb_mul_seq_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_cmp = 0;
  int n_bad = 0;

  mul_seq_param #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic mode, input logic [15:0] a, input logic [15:0] b);
    longint x, y;
    if (mode) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'(a);
      y = longint'(b);
    end
    return 32'(x * y);
  endfunction

  // Launches one operation and reports what was observed; the calling
  // scenario decides what those observations should have been.
  task automatic run_op(input logic mode, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [31:0] prod, output logic busy_e0,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    start = 1'b1; signed_mode = mode; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); signed_mode = 1'($urandom);
    busy_e0 = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    prod = product;
    @(posedge clk);
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (product !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_product got %h want 0", product); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        modes [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] as    [5] = '{16'h0007, 16'hFFFF, 16'h8000, 16'hFFFD, 16'h0004};
    logic [15:0] bs    [5] = '{16'h0005, 16'hFFFF, 16'h8000, 16'h0005, 16'hFFFF};
    logic [31:0] exps  [5] = '{32'h00000023, 32'hFFFE0001, 32'h40000000, 32'hFFFFFFF1, 32'hFFFFFFFC};
    int lat; logic [31:0] prod; logic be, da, ba;
    for (int i = 0; i < 5; i++) begin
      run_op(modes[i], as[i], bs[i], lat, prod, be, da, ba);
      n_cmp++; if (be !== 1'b1) begin n_bad++; $display("[TB] FAIL dir%0d_busy got %b want 1", i, be); end
      n_cmp++; if (lat != 16) begin n_bad++; $display("[TB] FAIL dir%0d_latency got %0d want 16", i, lat); end
      n_cmp++; if (prod !== exps[i]) begin n_bad++; $display("[TB] FAIL dir%0d_product got %h want %h", i, prod, exps[i]); end
      n_cmp++; if (da !== 1'b0) begin n_bad++; $display("[TB] FAIL dir%0d_done_width got %b want 0", i, da); end
      n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("[TB] FAIL dir%0d_idle got %b want 0", i, ba); end
    end
  endtask

  task automatic test_zero();
    logic        modes [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] as    [3] = '{16'h0000, 16'hABCD, 16'h0000};
    logic [15:0] bs    [3] = '{16'h1234, 16'h0000, 16'h0000};
    int lat; logic [31:0] prod; logic be, da, ba;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, 16'h1111, 16'h0003, lat, prod, be, da, ba);
      run_op(modes[i], as[i], bs[i], lat, prod, be, da, ba);
      n_cmp++; if (lat != 0) begin n_bad++; $display("[TB] FAIL zero%0d_latency got %0d want 0", i, lat); end
      n_cmp++; if (prod !== 32'h0) begin n_bad++; $display("[TB] FAIL zero%0d_product got %h want 0", i, prod); end
      n_cmp++; if (da !== 1'b0 || ba !== 1'b0) begin n_bad++; $display("[TB] FAIL zero%0d_return got done=%b busy=%b want 0/0", i, da, ba); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] prod, exp_p; logic be, da, ba, m; logic [15:0] a, b; int exp_lat;
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      if (i % 6 == 0) a = 16'h8000;
      exp_p = ref_mul(m, a, b);
      exp_lat = (a == 0 || b == 0) ? 0 : 16;
      run_op(m, a, b, lat, prod, be, da, ba);
      n_cmp++; if (prod !== exp_p) begin n_bad++; $display("[TB] FAIL rand%0d_product m=%b a=%h b=%h got %h want %h", i, m, a, b, prod, exp_p); end
      n_cmp++; if (lat != exp_lat) begin n_bad++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat); end
    end
  endtask

  // A second start arrives at E5 while the first operation is in flight.
  task automatic test_busy_start();
    logic [15:0] a, b; logic [31:0] exp_p, prev, held_bad; int first, pulses;
    a = 16'($urandom) | 16'h0001; b = 16'($urandom) | 16'h0100;
    exp_p = ref_mul(1'b1, a, b);
    prev = product; held_bad = '0; first = 0; pulses = 0;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin start = 1'b1; signed_mode = 1'b0; a_in = 16'h0003; b_in = 16'h0007; end
      @(posedge clk);
      @(negedge clk);
      if (k == 5) start = 1'b0;
      if (k < 16 && product !== prev) held_bad = product;
      if (done) begin pulses++; if (first == 0) first = k; end
    end
    n_cmp++; if (held_bad !== 32'h0) begin n_bad++; $display("[TB] FAIL busy_hold product changed to %h want %h", held_bad, prev); end
    n_cmp++; if (first != 16) begin n_bad++; $display("[TB] FAIL busy_latency got %0d want 16", first); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("[TB] FAIL busy_pulses got %0d want 1", pulses); end
    n_cmp++; if (product !== exp_p) begin n_bad++; $display("[TB] FAIL busy_product got %h want %h", product, exp_p); end
  endtask

  task automatic test_reset_abort();
    int pulses, lat; logic [31:0] prod, exp_p; logic be, da, ba;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a_in = 16'h1234; b_in = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_done got %b want 0", done); end
    n_cmp++; if (product !== 32'h0) begin n_bad++; $display("[TB] FAIL abort_product got %h want 0", product); end
    pulses = 0;
    for (int k = 0; k < 25; k++) begin @(posedge clk); @(negedge clk); if (done) pulses++; end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("[TB] FAIL abort_late_done got %0d want 0", pulses); end
    exp_p = ref_mul(1'b1, 16'hF00D, 16'h0123);
    run_op(1'b1, 16'hF00D, 16'h0123, lat, prod, be, da, ba);
    n_cmp++; if (prod !== exp_p) begin n_bad++; $display("[TB] FAIL abort_fresh_product got %h want %h", prod, exp_p); end
    n_cmp++; if (lat != 16) begin n_bad++; $display("[TB] FAIL abort_fresh_latency got %0d want 16", lat); end
  endtask

  // start held high: the second operation is accepted two edges after done.
  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2; logic [31:0] p1, p2; int first, second;
    a1 = 16'($urandom) | 16'h0001; b1 = 16'($urandom) | 16'h0001;
    a2 = 16'($urandom) | 16'h0002; b2 = 16'($urandom) | 16'h8000;
    first = 0; second = 0; p1 = '0; p2 = '0;
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a_in = a1; b_in = b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done && first == 0) begin first = k; p1 = product; a_in = a2; b_in = b2; end
      else if (done && second == 0) begin second = k; p2 = product; start = 1'b0; end
    end
    start = 1'b0;
    n_cmp++; if (first != 16) begin n_bad++; $display("[TB] FAIL b2b_first_latency got %0d want 16", first); end
    n_cmp++; if (second != 34) begin n_bad++; $display("[TB] FAIL b2b_second_latency got %0d want 34", second); end
    n_cmp++; if (p1 !== ref_mul(1'b0, a1, b1)) begin n_bad++; $display("[TB] FAIL b2b_product1 got %h want %h", p1, ref_mul(1'b0, a1, b1)); end
    n_cmp++; if (p2 !== ref_mul(1'b0, a2, b2)) begin n_bad++; $display("[TB] FAIL b2b_product2 got %h want %h", p2, ref_mul(1'b0, a2, b2)); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_busy_start();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
